mmio_button_events: RTL and testbench



---
 rtl/mmio_button_events_pkg.sv | 15 +
 rtl/mmio_button_events_if.sv | 11 +
 rtl/mmio_button_events_btn_debounce.sv | 46 ++++
 rtl/mmio_button_events.sv | 92 +++++++++
 tb/tb_mmio_button_events.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_button_events_pkg.sv
// Shared constants for the button event block: register offsets and press-count sizing.
package mmio_button_events_pkg;

    localparam int unsigned OFF_LEVEL = 0;
    localparam int unsigned OFF_PEND  = 1;
    localparam int unsigned OFF_CNT   = 2;

    localparam int unsigned CNT_W   = 8;
    localparam logic [7:0]  CNT_MAX = 8'hFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_button_events_if.sv
// Processor data-bus view of the button event register window.
interface mmio_button_events_if;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        hit;

    modport master (output wEn, output addr, output dataIn, input dataOut, input hit);
    modport slave  (input wEn, input addr, input dataIn, output dataOut, output hit);
endinterface

// File: rtl/mmio_button_events_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level and press strobe.
module mmio_button_events_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    localparam int unsigned CNT_BITS = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_stable;
    logic                r_stable_prev;
    logic [CNT_BITS-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_stable      <= 1'b0;
            r_stable_prev <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_sync1       <= i_raw;
            r_sync2       <= r_sync1;
            r_stable_prev <= r_stable;
            // Any return to the accepted level restarts the stability window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_press = r_stable & ~r_stable_prev;

endmodule

// File: rtl/mmio_button_events.sv
// Button status window: per-button debounce, sticky pending bits (W1C) and saturating press counts.
module mmio_button_events
    import mmio_button_events_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [11:0] BASE_ADDR       = 12'd1008
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_BTN-1:0]   btn_raw,
    mmio_button_events_if.slave  bus,
    output logic                 event_pending,
    output logic [NUM_BTN-1:0]   btn_level
);
    logic [NUM_BTN-1:0]            w_press;
    logic [NUM_BTN-1:0]            w_level;
    logic [NUM_BTN-1:0]            r_pend;
    logic [NUM_BTN-1:0]            w_pend_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_BTN-1:0][CNT_W-1:0] w_cnt_d;
    logic [11:0]                   w_off;
    logic                          w_wr_pend;
    logic                          w_wr_cnt;
    logic                          w_unused_data;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        mmio_button_events_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .i_raw  (btn_raw[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );
    end

    assign btn_level     = w_level;
    assign w_off         = bus.addr - BASE_ADDR;
    assign bus.hit       = (bus.addr >= BASE_ADDR) && (bus.addr <= BASE_ADDR + 12'd2);
    assign w_wr_pend     = bus.wEn && bus.hit && (w_off == 12'(OFF_PEND));
    assign w_wr_cnt      = bus.wEn && bus.hit && (w_off == 12'(OFF_CNT));
    assign w_unused_data = ^bus.dataIn[31:NUM_BTN];

    // Clear is applied first and the press on top, so a same-cycle press wins.
    always_comb begin
        w_pend_d = r_pend;
        w_cnt_d  = r_cnt;
        if (w_wr_pend) begin
            w_pend_d = r_pend & ~bus.dataIn[NUM_BTN-1:0];
        end
        w_pend_d = w_pend_d | w_press;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_wr_cnt && bus.dataIn[i]) begin
                w_cnt_d[i] = '0;
            end
            if (w_press[i]) begin
                w_cnt_d[i] = sat_inc(w_cnt_d[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend        <= '0;
            r_cnt         <= '0;
            event_pending <= 1'b0;
        end else begin
            r_pend        <= w_pend_d;
            r_cnt         <= w_cnt_d;
            event_pending <= |w_pend_d;
        end
    end

    always_comb begin
        bus.dataOut = '0;
        if (bus.hit) begin
            case (w_off[1:0])
                2'(OFF_LEVEL): bus.dataOut[NUM_BTN-1:0] = w_level;
                2'(OFF_PEND):  bus.dataOut[NUM_BTN-1:0] = r_pend;
                2'(OFF_CNT): begin
                    for (int i = 0; i < NUM_BTN; i++) begin
                        bus.dataOut[i*CNT_W +: CNT_W] = r_cnt[i];
                    end
                end
                default: bus.dataOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_button_events.sv
// Scoreboard bench: stimulus pushes model-derived expectations, a negedge monitor pops and compares.
module tb_mmio_button_events;

    localparam int unsigned NB   = 3;
    localparam int unsigned DEB  = 4;
    localparam logic [11:0] BASE = 12'd1008;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
        logic [2:0]  lvl;
        logic        ep;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] btn_raw;
    logic          event_pending;
    logic [NB-1:0] btn_level;
    logic          tb_rd;

    mmio_button_events_if bus ();

    mmio_button_events #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .bus          (bus),
        .event_pending(event_pending),
        .btn_level    (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what software should observe, from the register rules alone.
    logic [2:0] pend_m;
    int         cnt_m [3];

    exp_t  q_exp  [$];
    string q_name [$];
    int    n_run;
    int    n_fail;

    function automatic logic [31:0] mdl_read(input logic [11:0] a, input logic [2:0] lvl);
        if (a == BASE)         return {29'd0, lvl};
        if (a == BASE + 12'd1) return {29'd0, pend_m};
        if (a == BASE + 12'd2) return {8'd0, cnt_m[2][7:0], cnt_m[1][7:0], cnt_m[0][7:0]};
        return 32'd0;
    endfunction

    function automatic void mdl_press(input logic [2:0] mask);
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                pend_m[i] = 1'b1;
                if (cnt_m[i] < 255) cnt_m[i] = cnt_m[i] + 1;
            end
        end
    endfunction

    function automatic void mdl_write(input logic [11:0] a, input logic [31:0] d);
        for (int i = 0; i < 3; i++) begin
            if (a == BASE + 12'd1 && d[i]) pend_m[i] = 1'b0;
            if (a == BASE + 12'd2 && d[i]) cnt_m[i] = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (tb_rd) begin
            n_run++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: read with no expectation queued");
            end else begin
                exp_t  e;
                string nm;
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                if (bus.dataOut !== e.data || bus.hit !== e.hit ||
                    btn_level !== e.lvl || event_pending !== e.ep) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h hit=%b lvl=%b ep=%b, expected data=%h hit=%b lvl=%b ep=%b",
                             nm, bus.dataOut, bus.hit, btn_level, event_pending,
                             e.data, e.hit, e.lvl, e.ep);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] a, input logic [2:0] lvl);
        exp_t e;
        e.hit  = (a >= BASE) && (a <= BASE + 12'd2);
        e.data = e.hit ? mdl_read(a, lvl) : 32'd0;
        e.lvl  = lvl;
        e.ep   = |pend_m;
        q_exp.push_back(e);
        q_name.push_back(nm);
        bus.wEn  = 1'b0;
        bus.addr = a;
        tb_rd    = 1'b1;
        @(posedge clk);
        #1;
        tb_rd = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.wEn    = 1'b1;
        bus.addr   = a;
        bus.dataIn = d;
        @(posedge clk);
        #1;
        bus.wEn = 1'b0;
        mdl_write(a, d);
    endtask

    task automatic press(input logic [2:0] mask);
        btn_raw = mask;
        idle(8);
        btn_raw = '0;
        idle(8);
        mdl_press(mask);
    endtask

    // Press btn0 cleanly and land a write on the exact cycle its press strobe is high.
    task automatic collide(input logic [11:0] a, input logic [31:0] d);
        btn_raw[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.wEn    = 1'b1;
        bus.addr   = a;
        bus.dataIn = d;
        @(posedge clk);
        #1;
        bus.wEn = 1'b0;
        mdl_write(a, d);
        mdl_press(3'b001);
        idle(3);
        btn_raw = '0;
        idle(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_run      = 0;
        n_fail     = 0;
        tb_rd      = 1'b0;
        pend_m     = '0;
        cnt_m      = '{0, 0, 0};
        bus.wEn    = 1'b0;
        bus.addr   = 12'd0;
        bus.dataIn = 32'd0;
        btn_raw    = 3'b111;
        reset_n    = 1'b0;
        idle(3);

        chk("rst_level", BASE, 3'b000);
        chk("rst_pend", BASE + 12'd1, 3'b000);
        chk("rst_cnt", BASE + 12'd2, 3'b000);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) chk("rst_latency_low", BASE, 3'b000);
        chk("rst_latency_high", BASE, 3'b111);
        mdl_press(3'b111);
        chk("rst_press_pending", BASE + 12'd1, 3'b111);
        chk("rst_press_count", BASE + 12'd2, 3'b111);
        btn_raw = '0;
        idle(10);
        chk("released_level", BASE, 3'b000);
        wr(BASE + 12'd1, 32'h7);
        wr(BASE + 12'd2, 32'h7);
        chk("cleared_count", BASE + 12'd2, 3'b000);

        // Bounce: 2-cycle runs never fill the stability window.
        for (int p = 0; p < 4; p++) begin
            btn_raw[0] = ~p[0];
            chk("bounce_low", BASE, 3'b000);
            chk("bounce_low", BASE, 3'b000);
        end
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 6; k++) chk("bounce_settle_low", BASE, 3'b000);
        chk("bounce_settle_high", BASE, 3'b001);
        mdl_press(3'b001);
        chk("bounce_pending", BASE + 12'd1, 3'b001);
        btn_raw = '0;
        idle(10);
        chk("bounce_one_press", BASE + 12'd2, 3'b000);

        wr(BASE + 12'd1, 32'h7);
        press(3'b011);
        chk("w1c_both", BASE + 12'd1, 3'b000);
        wr(BASE + 12'd1, 32'h2);
        chk("w1c_bit1", BASE + 12'd1, 3'b000);
        wr(BASE + 12'd1, 32'h1);
        chk("w1c_bit0", BASE + 12'd1, 3'b000);

        wr(BASE + 12'd2, 32'h7);
        for (int k = 0; k < 300; k++) press(3'b100);
        chk("saturate", BASE + 12'd2, 3'b000);
        wr(BASE + 12'd2, 32'h4);
        chk("saturate_clear", BASE + 12'd2, 3'b000);

        wr(BASE + 12'd1, 32'h7);
        press(3'b010);
        collide(BASE + 12'd1, 32'h3);
        chk("collide_pending", BASE + 12'd1, 3'b000);
        press(3'b011);
        press(3'b001);
        collide(BASE + 12'd2, 32'h3);
        chk("collide_count", BASE + 12'd2, 3'b000);

        chk("decode_above", BASE + 12'd3, 3'b000);
        chk("decode_below", BASE - 12'd1, 3'b000);
        wr(BASE, 32'hFFFF_FFFF);
        wr(BASE + 12'd3, 32'hFFFF_FFFF);
        bus.dataIn = 32'hFFFF_FFFF;
        chk("no_wen_pend", BASE + 12'd1, 3'b000);
        chk("no_wen_cnt", BASE + 12'd2, 3'b000);

        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 3))
                0: press(3'($urandom_range(1, 7)));
                1: wr(BASE + 12'd1, $urandom);
                2: wr(BASE + 12'd2, $urandom);
                default: wr(12'($urandom_range(1011, 1030)), $urandom);
            endcase
            chk("rand_pend", BASE + 12'd1, 3'b000);
            chk("rand_cnt", BASE + 12'd2, 3'b000);
        end

        idle(2);
        n_run++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d unchecked entries, expected 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
